wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DEPTH, default 2, meaning: writeback buffer entries (power of two, >= 2).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset, synchronous and active-low.
REQ-004 mem_valid  input  1  memory-stage result valid.
REQ-005 mem_ready  output  1  wb_stage accepts a result this cycle.
REQ-006 mem_rd  input  5  destination register index.
REQ-007 mem_alu_res  input  32  ALU result; for loads, the byte address (bits [1:0] = offset).
REQ-008 mem_data  input  32  raw aligned load word from data memory.
REQ-009 mem_is_load  input  1  result is a load; select extracted mem_data, else mem_alu_res.
REQ-010 mem_funct3  input  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 rf_we  output  1  register-file write strobe.
REQ-012 rf_waddr  output  5  register-file write index.
REQ-013 rf_wdata  output  32  register-file write data.
REQ-014 rf_ready  input  1  register-file write port granted this cycle (shared with CSR path).
REQ-015 fwd_valid  output  1  head entry holds a pending write.
REQ-016 fwd_rd  output  5  head entry index, for decode-stage forwarding.
REQ-017 fwd_data  output  32  head entry data, for decode-stage forwarding.
REQ-018 retire_cnt  output  32  count of committed register-file writes.

Function
REQ-019 Input transfer occurs when mem_valid && mem_ready; mem_ready = !full, independent of mem_valid and rf_ready.
REQ-020 On transfer, write data is computed combinationally and stored with rd in the tail entry; the buffer holds final write data only.
REQ-021 LB/LBU select byte mem_data[8*off+7 : 8*off] (off = mem_alu_res[1:0]); LB sign-extends, LBU zero-extends.
REQ-022 LH/LHU select halfword by mem_alu_res[1] only (bit 0 ignored); LH sign-extends, LHU zero-extends.
REQ-023 LW passes mem_data unchanged, ignoring the offset.
REQ-024 Unlisted funct3 values with mem_is_load=1 are treated as LW.
REQ-025 Transfers with mem_rd = 0 are accepted (mem_ready rules unchanged), are not enqueued, and are not counted.
REQ-026 rf_we = !empty; rf_waddr/rf_wdata = head entry; a commit occurs when rf_we && rf_ready.
REQ-027 Latency: a result accepted in cycle N drives rf_we in cycle N+1 at the earliest; there is no input-to-output combinational path.
REQ-028 rf_waddr/rf_wdata hold stable while rf_we=1 and rf_ready=0.
REQ-029 Simultaneous enqueue and commit: both take effect and occupancy is unchanged; when full, mem_ready=0 even if rf_ready=1 (no pass-through).
REQ-030 Pointers wrap modulo DEPTH; full/empty derive from an occupancy counter of width clog2(DEPTH)+1.
REQ-031 fwd_valid/fwd_rd/fwd_data mirror rf_we/rf_waddr/rf_wdata.
REQ-032 retire_cnt increments by 1 per commit and wraps from 0xFFFFFFFF to 0.

Reset
REQ-033 When reset=0 at posedge clk: occupancy, pointers and retire_cnt go to 0.
REQ-034 During and after reset: rf_we=0, fwd_valid=0, rf_waddr=0, rf_wdata=0, fwd_rd=0, fwd_data=0, mem_ready=1.
REQ-035 Reset mid-operation discards all buffered entries without committing; a transfer in the reset cycle is dropped.

Verification
REQ-036 ALU result: mem_rd=5, alu_res=0x1234_5678, is_load=0, rf_ready=1 -> cycle N+1: rf_we=1, waddr=5, wdata=0x1234_5678; retire_cnt=1.
REQ-037 Load extraction: mem_data=0x80FF_7F01; LB off=3 -> 0xFFFF_FF80; LBU off=2 -> 0x0000_00FF; LH off=2 -> 0xFFFF_80FF; LHU off=0 -> 0x0000_7F01.
REQ-038 Backpressure: rf_ready=0 with 2 results pushed -> mem_ready=0 after the 2nd, head stable; rf_ready=1 -> both commit in order, mem_ready reasserts.
REQ-039 x0 drop: mem_rd=0, valid=1 -> mem_ready=1, rf_we stays 0, retire_cnt unchanged.
REQ-040 Reset mid-operation: buffer full, reset=0 for one cycle -> next cycle rf_we=0, mem_ready=1, retire_cnt=0.
REQ-041 Simultaneous: occupancy 1, push with rf_ready=1 -> occupancy stays 1, order preserved over 8 back-to-back pushes.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: writeback buffer between the memory stage and the register file.
// Results are turned into final write data (load byte/halfword extraction and
// extension) on the way in and queued in a DEPTH-entry FIFO. The head entry
// drives the register-file write port and the decode-stage forwarding taps.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   mem_valid/ready   memory-stage handshake (ready = buffer not full)
//   mem_rd            destination register (x0 results are accepted and dropped)
//   mem_alu_res       ALU result, or load byte address (bits [1:0] = offset)
//   mem_data          raw aligned load word
//   mem_is_load       select extracted load data instead of the ALU result
//   mem_funct3        load size/sign (LB/LH/LW/LBU/LHU; others behave as LW)
//   rf_we/waddr/wdata register-file write port, driven from the head entry
//   rf_ready          write port granted; commit = rf_we && rf_ready
//   fwd_valid/rd/data copy of the head entry for forwarding
//   retire_cnt        number of committed writes (wraps)
module wb_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_alu_res,
  input  logic [31:0] mem_data,
  input  logic        mem_is_load,
  input  logic [2:0]  mem_funct3,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic        rf_ready,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic [31:0] retire_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [4:0]    r_rd   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_retire;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_commit;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_wdata;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // x0 writes complete the handshake but never occupy an entry.
  assign w_push   = mem_valid && !w_full && (mem_rd != 5'd0);
  assign w_commit = !w_empty && rf_ready;

  always_comb begin
    w_byte  = '0;
    w_half  = '0;
    w_wdata = mem_alu_res;
    case (mem_alu_res[1:0])
      2'd0:    w_byte = mem_data[7:0];
      2'd1:    w_byte = mem_data[15:8];
      2'd2:    w_byte = mem_data[23:16];
      default: w_byte = mem_data[31:24];
    endcase
    w_half = mem_alu_res[1] ? mem_data[31:16] : mem_data[15:0];
    if (mem_is_load) begin
      case (mem_funct3)
        3'b000:  w_wdata = {{24{w_byte[7]}}, w_byte};
        3'b001:  w_wdata = {{16{w_half[15]}}, w_half};
        3'b100:  w_wdata = {24'd0, w_byte};
        3'b101:  w_wdata = {16'd0, w_half};
        default: w_wdata = mem_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_retire <= '0;
    end else begin
      if (w_push) begin
        r_rd[r_wptr]   <= mem_rd;
        r_data[r_wptr] <= w_wdata;
        r_wptr         <= r_wptr + AW'(1);
      end
      if (w_commit) begin
        r_rptr   <= r_rptr + AW'(1);
        r_retire <= r_retire + 32'd1;
      end
      case ({w_push, w_commit})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head fields are forced to zero when empty so stale entries never show.
  assign mem_ready  = !w_full;
  assign rf_we      = !w_empty;
  assign rf_waddr   = w_empty ? 5'd0  : r_rd[r_rptr];
  assign rf_wdata   = w_empty ? 32'd0 : r_data[r_rptr];
  assign fwd_valid  = rf_we;
  assign fwd_rd     = rf_waddr;
  assign fwd_data   = rf_wdata;
  assign retire_cnt = r_retire;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_alu_res = '0;
  logic [31:0] mem_data = '0;
  logic        mem_is_load = 1'b0;
  logic [2:0]  mem_funct3 = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_ready = 1'b0;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [31:0] retire_cnt;

  wb_stage #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_alu_res(mem_alu_res), .mem_data(mem_data),
    .mem_is_load(mem_is_load), .mem_funct3(mem_funct3),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_ready(rf_ready),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_retire = '0;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: runs on the falling edge, away from stimulus changes.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("retire_cnt", retire_cnt, exp_retire);
      if (!reset) begin
        sb.delete();
        exp_retire = '0;
      end else if (rf_we && rf_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: got rd=%0d data=0x%08h expected none", rf_waddr, rf_wdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("commit_waddr", 32'(rf_waddr), 32'(e.rd));
          chk("commit_wdata", rf_wdata, e.d);
          chk("fwd_valid", 32'(fwd_valid), 32'd1);
          chk("fwd_rd", 32'(fwd_rd), 32'(e.rd));
          chk("fwd_data", fwd_data, e.d);
        end
        exp_retire = exp_retire + 32'd1;
      end
    end
  end

  // Offer one result; returns #1 after the edge on which it was accepted.
  task automatic push(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] dat,
                      input logic ld, input logic [2:0] f3, input logic [31:0] exp);
    int n;
    mem_valid = 1'b1; mem_rd = rd; mem_alu_res = alu; mem_data = dat;
    mem_is_load = ld; mem_funct3 = f3;
    n = 0;
    while (!mem_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!mem_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got mem_ready=0 expected 1 within 20 cycles");
      mem_valid = 1'b0;
    end else begin
      if (rd != 5'd0) sb.push_back('{rd: rd, d: exp});
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    mem_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_fwd_rd", 32'(fwd_rd), 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("rst_retire", retire_cnt, 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;

    // ALU result, latency of one cycle
    rf_ready = 1'b1;
    push(5'd5, 32'h1234_5678, 32'h0, 1'b0, 3'b000, 32'h1234_5678);
    mem_valid = 1'b0;
    chk("lat_rf_we", 32'(rf_we), 32'd1);
    chk("lat_waddr", 32'(rf_waddr), 32'd5);
    chk("lat_wdata", rf_wdata, 32'h1234_5678);
    idle(1);
    chk("alu_retire", retire_cnt, 32'd1);
    chk("alu_empty", 32'(rf_we), 32'd0);

    // Load extraction, back-to-back with commits
    push(5'd1, 32'h0000_1003, 32'h80FF_7F01, 1'b1, 3'b000, 32'hFFFF_FF80);
    push(5'd2, 32'h0000_1002, 32'h80FF_7F01, 1'b1, 3'b100, 32'h0000_00FF);
    push(5'd3, 32'h0000_1002, 32'h80FF_7F01, 1'b1, 3'b001, 32'hFFFF_80FF);
    push(5'd4, 32'h0000_1000, 32'h80FF_7F01, 1'b1, 3'b101, 32'h0000_7F01);
    push(5'd6, 32'h0000_1000, 32'h80FF_7F01, 1'b1, 3'b000, 32'h0000_0001);
    push(5'd7, 32'h0000_1003, 32'h80FF_7F01, 1'b1, 3'b001, 32'hFFFF_80FF);
    push(5'd8, 32'h0000_1001, 32'h80FF_7F01, 1'b1, 3'b010, 32'h80FF_7F01);
    push(5'd9, 32'h0000_1002, 32'h80FF_7F01, 1'b1, 3'b011, 32'h80FF_7F01);
    idle(3);
    chk("load_retire", retire_cnt, 32'd9);

    // Backpressure
    rf_ready = 1'b0;
    push(5'd10, 32'hAAAA_0001, 32'h0, 1'b0, 3'b000, 32'hAAAA_0001);
    push(5'd11, 32'hBBBB_0002, 32'h0, 1'b0, 3'b000, 32'hBBBB_0002);
    mem_valid = 1'b0;
    chk("bp_full", 32'(mem_ready), 32'd0);
    idle(3);
    chk("bp_hold_we", 32'(rf_we), 32'd1);
    chk("bp_hold_waddr", 32'(rf_waddr), 32'd10);
    chk("bp_hold_wdata", rf_wdata, 32'hAAAA_0001);
    chk("bp_still_full", 32'(mem_ready), 32'd0);
    rf_ready = 1'b1;
    idle(1);
    chk("bp_second_head", 32'(rf_waddr), 32'd11);
    chk("bp_ready_back", 32'(mem_ready), 32'd1);
    idle(1);
    chk("bp_drained", 32'(rf_we), 32'd0);

    // x0 drop
    chk("x0_ready", 32'(mem_ready), 32'd1);
    push(5'd0, 32'hDEAD_BEEF, 32'h0, 1'b0, 3'b000, 32'h0);
    mem_valid = 1'b0;
    chk("x0_no_we", 32'(rf_we), 32'd0);
    idle(2);
    chk("x0_retire", retire_cnt, 32'd11);

    // Reset while full, with a transfer offered in the reset cycle
    rf_ready = 1'b0;
    push(5'd12, 32'h0000_000C, 32'h0, 1'b0, 3'b000, 32'h0000_000C);
    push(5'd13, 32'h0000_000D, 32'h0, 1'b0, 3'b000, 32'h0000_000D);
    reset = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd14; mem_alu_res = 32'h0000_000E; mem_is_load = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    mem_valid = 1'b0;
    chk("mrst_we", 32'(rf_we), 32'd0);
    chk("mrst_ready", 32'(mem_ready), 32'd1);
    chk("mrst_retire", retire_cnt, 32'd0);
    rf_ready = 1'b1;
    idle(3);
    chk("mrst_no_commit", 32'(rf_we), 32'd0);

    // Simultaneous enqueue and commit: occupancy stays at 1
    for (int i = 0; i < 8; i++) begin
      chk("sim_ready", 32'(mem_ready), 32'd1);
      push(5'(16 + i), 32'h5000_0000 + 32'(i), 32'h0, 1'b0, 3'b000, 32'h5000_0000 + 32'(i));
      chk("sim_we", 32'(rf_we), 32'd1);
    end
    mem_valid = 1'b0;
    idle(3);
    chk("sim_retire", retire_cnt, 32'd8);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
